// File: rtl/ycbcr_conv_arbiter_pkg.sv
// Shared tag encoding and width helper for the YCbCr converter arbiter.
package ycbcr_conv_arbiter_pkg;

   typedef logic [1:0] tag_t;

   localparam tag_t REQ_NONE = 2'b00;
   localparam tag_t REQ0     = 2'b01;
   localparam tag_t REQ1     = 2'b10;

   function automatic int log2_ceil(input int value);
      int bits;
      bits = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) bits = i + 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/ycbcr_conv_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the requester not served last wins a tie.
module rr_arbiter2
   import ycbcr_conv_arbiter_pkg::*;
(
   input  logic clock,
   input  logic n_rst,
   input  logic [1:0] eligible,
   output tag_t grant
);

   // 1 means requester 1 was served last, so requester 0 wins the first tie
   logic last_grant;

   always_comb begin
      grant = REQ_NONE;
      if (&eligible) begin
         grant = last_grant ? REQ0 : REQ1;
      end else if (eligible[0]) begin
         grant = REQ0;
      end else if (eligible[1]) begin
         grant = REQ1;
      end
   end

   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         last_grant <= 1'b1;
      end else if (grant != REQ_NONE) begin
         last_grant <= grant[1];
      end
   end

endmodule

// File: rtl/ycbcr_conv_arbiter.sv
// Shares one fixed-latency RGB->YCbCr converter between two requesters and
// tags every in-flight pixel with its owner.
module ycbcr_conv_arbiter
   import ycbcr_conv_arbiter_pkg::*;
#(
   parameter int BIT_WIDTH    = 8,
   parameter int FRAME_HEIGHT = 480,
   parameter int FRAME_WIDTH  = 640,
   parameter int CONV_LATENCY = 4,
   localparam int V_BITW      = log2_ceil(FRAME_HEIGHT),
   localparam int H_BITW      = log2_ceil(FRAME_WIDTH)
) (
   input  logic                 clock,
   input  logic                 n_rst,
   input  logic [1:0]           enable,
   input  logic                 flush,
   output logic                 idle,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [BIT_WIDTH-1:0] req0_r,
   input  logic [BIT_WIDTH-1:0] req0_g,
   input  logic [BIT_WIDTH-1:0] req0_b,
   input  logic [V_BITW-1:0]    req0_vcnt,
   input  logic [H_BITW-1:0]    req0_hcnt,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [BIT_WIDTH-1:0] req1_r,
   input  logic [BIT_WIDTH-1:0] req1_g,
   input  logic [BIT_WIDTH-1:0] req1_b,
   input  logic [V_BITW-1:0]    req1_vcnt,
   input  logic [H_BITW-1:0]    req1_hcnt,
   output logic [BIT_WIDTH-1:0] cv_r,
   output logic [BIT_WIDTH-1:0] cv_g,
   output logic [BIT_WIDTH-1:0] cv_b,
   output logic [V_BITW-1:0]    cv_vcnt,
   output logic [H_BITW-1:0]    cv_hcnt,
   input  logic [BIT_WIDTH-1:0] cv_y,
   input  logic [BIT_WIDTH-1:0] cv_cb,
   input  logic [BIT_WIDTH-1:0] cv_cr,
   input  logic [V_BITW-1:0]    cv_out_vcnt,
   input  logic [H_BITW-1:0]    cv_out_hcnt,
   output tag_t                 out_valid,
   output logic [BIT_WIDTH-1:0] out_y,
   output logic [BIT_WIDTH-1:0] out_cb,
   output logic [BIT_WIDTH-1:0] out_cr,
   output logic [V_BITW-1:0]    out_vcnt,
   output logic [H_BITW-1:0]    out_hcnt
);

   logic [1:0] eligible;
   tag_t       grant;
   tag_t       tag_pipe [0:CONV_LATENCY];
   logic       in_flight;

   assign eligible   = {req1_valid & enable[1] & ~flush,
                        req0_valid & enable[0] & ~flush};
   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   rr_arbiter2 u_rr (
      .clock    (clock),
      .n_rst    (n_rst),
      .eligible (eligible),
      .grant    (grant)
   );

   // Stage 0: converter input mux register; holds its value on idle cycles
   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         cv_r    <= '0;
         cv_g    <= '0;
         cv_b    <= '0;
         cv_vcnt <= '0;
         cv_hcnt <= '0;
      end else if (grant == REQ1) begin
         cv_r    <= req1_r;
         cv_g    <= req1_g;
         cv_b    <= req1_b;
         cv_vcnt <= req1_vcnt;
         cv_hcnt <= req1_hcnt;
      end else if (grant == REQ0) begin
         cv_r    <= req0_r;
         cv_g    <= req0_g;
         cv_b    <= req0_b;
         cv_vcnt <= req0_vcnt;
         cv_hcnt <= req0_hcnt;
      end
   end

   // Tag stages 0..CONV_LATENCY track the mux register plus the converter
   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         for (int k = 0; k <= CONV_LATENCY; k++) tag_pipe[k] <= REQ_NONE;
      end else begin
         tag_pipe[0] <= grant;
         for (int k = 1; k <= CONV_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
      end
   end

   // Output stage: registered converter result, flagged by the tail tag
   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         out_valid <= REQ_NONE;
         out_y     <= '0;
         out_cb    <= '0;
         out_cr    <= '0;
         out_vcnt  <= '0;
         out_hcnt  <= '0;
      end else begin
         out_valid <= tag_pipe[CONV_LATENCY];
         out_y     <= cv_y;
         out_cb    <= cv_cb;
         out_cr    <= cv_cr;
         out_vcnt  <= cv_out_vcnt;
         out_hcnt  <= cv_out_hcnt;
      end
   end

   always_comb begin
      in_flight = 1'b0;
      for (int k = 0; k <= CONV_LATENCY; k++) begin
         if (tag_pipe[k] != REQ_NONE) in_flight = 1'b1;
      end
   end

   assign idle = (grant == REQ_NONE) && !in_flight && (out_valid == REQ_NONE);

endmodule

// File: tb/tb_ycbcr_conv_arbiter.sv
// Randomized bench for ycbcr_conv_arbiter with an attached 4-cycle converter
// model and a transaction-level scoreboard.
module tb_ycbcr_conv_arbiter;

   localparam int BW  = 8;
   localparam int VW  = 9;
   localparam int HW  = 10;
   localparam int LAT = 6;
   localparam int PW  = 3*BW + VW + HW;

   logic          clock = 1'b0;
   logic          n_rst;
   logic [1:0]    en;
   logic          fl;
   logic          idle;
   logic          v0, v1, rdy0, rdy1;
   logic [BW-1:0] r0, g0, b0, r1, g1, b1;
   logic [VW-1:0] vc0, vc1;
   logic [HW-1:0] hc0, hc1;
   logic [BW-1:0] cv_r, cv_g, cv_b, cv_y, cv_cb, cv_cr;
   logic [VW-1:0] cv_vcnt, cv_out_vcnt;
   logic [HW-1:0] cv_hcnt, cv_out_hcnt;
   logic [1:0]    out_valid;
   logic [BW-1:0] out_y, out_cb, out_cr;
   logic [VW-1:0] out_vcnt;
   logic [HW-1:0] out_hcnt;

   always #5 clock = ~clock;

   ycbcr_conv_arbiter dut (
      .clock(clock), .n_rst(n_rst), .enable(en), .flush(fl), .idle(idle),
      .req0_valid(v0), .req0_ready(rdy0), .req0_r(r0), .req0_g(g0), .req0_b(b0),
      .req0_vcnt(vc0), .req0_hcnt(hc0),
      .req1_valid(v1), .req1_ready(rdy1), .req1_r(r1), .req1_g(g1), .req1_b(b1),
      .req1_vcnt(vc1), .req1_hcnt(hc1),
      .cv_r(cv_r), .cv_g(cv_g), .cv_b(cv_b), .cv_vcnt(cv_vcnt), .cv_hcnt(cv_hcnt),
      .cv_y(cv_y), .cv_cb(cv_cb), .cv_cr(cv_cr),
      .cv_out_vcnt(cv_out_vcnt), .cv_out_hcnt(cv_out_hcnt),
      .out_valid(out_valid), .out_y(out_y), .out_cb(out_cb), .out_cr(out_cr),
      .out_vcnt(out_vcnt), .out_hcnt(out_hcnt)
   );

   function automatic logic [7:0] sat8(input int x);
      if (x < 0) return 8'd0;
      if (x > 255) return 8'd255;
      return x[7:0];
   endfunction

   // Full-range BT.601 with 8-bit fractional coefficients
   function automatic logic [23:0] ycc(input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b);
      int ri, gi, bi, y, cb, cr;
      ri = int'(r);
      gi = int'(g);
      bi = int'(b);
      y  = (77*ri + 150*gi + 29*bi) >>> 8;
      cb = 128 + ((-43*ri - 85*gi + 128*bi) >>> 8);
      cr = 128 + ((128*ri - 107*gi - 21*bi) >>> 8);
      return {sat8(y), sat8(cb), sat8(cr)};
   endfunction

   // Converter: four register stages between cv_* and cv_y/cv_out_*
   logic [PW-1:0] cpipe [0:3];
   logic [23:0]   cres;
   always_ff @(posedge clock) begin
      cpipe[0] <= {cv_r, cv_g, cv_b, cv_vcnt, cv_hcnt};
      for (int k = 1; k < 4; k++) cpipe[k] <= cpipe[k-1];
   end
   always_comb begin
      cres        = ycc(cpipe[3][42:35], cpipe[3][34:27], cpipe[3][26:19]);
      cv_y        = cres[23:16];
      cv_cb       = cres[15:8];
      cv_cr       = cres[7:0];
      cv_out_vcnt = cpipe[3][18:10];
      cv_out_hcnt = cpipe[3][9:0];
   end

   typedef struct {
      int            due;
      logic [1:0]    own;
      logic [BW-1:0] r, g, b;
      logic [VW-1:0] v;
      logic [HW-1:0] h;
   } item_t;

   item_t q[$];
   int    errors = 0;
   int    checks = 0;
   int    cyc    = 0;
   int    beats  = 0;
   logic  last_is1 = 1'b1;
   logic  acc0, acc1, white;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic new_pix0();
      {r0, g0, b0} = white ? 24'hFFFFFF : 24'($urandom);
      if (hc0 == HW'(639)) begin
         hc0 = '0;
         vc0 = (vc0 == VW'(479)) ? '0 : vc0 + 1'b1;
      end else hc0 = hc0 + 1'b1;
   endtask

   task automatic new_pix1();
      {r1, g1, b1} = white ? 24'hFFFFFF : 24'($urandom);
      if (hc1 == HW'(639)) begin
         hc1 = '0;
         vc1 = (vc1 == VW'(479)) ? '0 : vc1 + 1'b1;
      end else hc1 = hc1 + 1'b1;
   endtask

   task automatic model_check();
      logic        e0, e1, exp_idle;
      logic [1:0]  g, exp_ov;
      logic [23:0] c;
      item_t       it;
      e0 = v0 & en[0] & ~fl;
      e1 = v1 & en[1] & ~fl;
      g  = 2'b00;
      if (e0 && e1) g = last_is1 ? 2'b01 : 2'b10;
      else if (e0)  g = 2'b01;
      else if (e1)  g = 2'b10;
      check_val("req0_ready", 32'(rdy0), 32'(g[0]));
      check_val("req1_ready", 32'(rdy1), 32'(g[1]));
      exp_idle = (g == 2'b00) && (q.size() == 0);
      check_val("idle", 32'(idle), 32'(exp_idle));
      exp_ov = 2'b00;
      if (q.size() > 0 && q[0].due == cyc) begin
         it     = q.pop_front();
         exp_ov = it.own;
         c      = ycc(it.r, it.g, it.b);
         beats++;
         check_val("out_y",    32'(out_y),    32'(c[23:16]));
         check_val("out_cb",   32'(out_cb),   32'(c[15:8]));
         check_val("out_cr",   32'(out_cr),   32'(c[7:0]));
         check_val("out_vcnt", 32'(out_vcnt), 32'(it.v));
         check_val("out_hcnt", 32'(out_hcnt), 32'(it.h));
      end
      check_val("out_valid", 32'(out_valid), 32'(exp_ov));
      acc0 = g[0];
      acc1 = g[1];
      if (g != 2'b00) begin
         it.due = cyc + LAT;
         it.own = g;
         if (g[0]) begin
            it.r = r0; it.g = g0; it.b = b0; it.v = vc0; it.h = hc0;
         end else begin
            it.r = r1; it.g = g1; it.b = b1; it.v = vc1; it.h = hc1;
         end
         q.push_back(it);
         last_is1 = g[1];
      end
   endtask

   task automatic run_cycle();
      @(negedge clock);
      model_check();
      @(posedge clock);
      cyc++;
      #1;
      if (acc0) new_pix0();
      if (acc1) new_pix1();
   endtask

   initial begin
      n_rst = 1'b0; en = 2'b11; fl = 1'b0; v0 = 1'b0; v1 = 1'b0; white = 1'b0;
      {r0, g0, b0, r1, g1, b1} = '0;
      vc0 = '0; hc0 = '0; vc1 = 9'd100; hc1 = 10'd300;
      acc0 = 1'b0; acc1 = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_idle", 32'(idle), 32'd1);
      check_val("rst_cv", 32'({cv_r, cv_g, cv_b}), 32'd0);
      check_val("rst_out", 32'({out_y, out_cb, out_cr}), 32'd0);
      n_rst = 1'b1;
      repeat (20) run_cycle();

      // requester 0 alone with white pixels
      white = 1'b1; new_pix0(); v0 = 1'b1;
      repeat (14) run_cycle();
      white = 1'b0; v0 = 1'b0;
      repeat (8) run_cycle();

      // both continuously valid: strict alternation
      new_pix0(); new_pix1(); v0 = 1'b1; v1 = 1'b1;
      repeat (16) run_cycle();

      // requester 0 masked off
      en = 2'b10;
      repeat (12) run_cycle();
      en = 2'b11; v0 = 1'b0; v1 = 1'b0;
      repeat (8) run_cycle();

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         v0 = ($urandom_range(0, 9) < 7);
         v1 = ($urandom_range(0, 9) < 7);
         en = ($urandom_range(0, 9) < 7) ? 2'b11 : 2'($urandom);
         fl = ($urandom_range(0, 9) == 0);
         run_cycle();
      end
      v0 = 1'b0; v1 = 1'b0; fl = 1'b0; en = 2'b11;
      repeat (8) run_cycle();

      // flush with three pixels in flight
      beats = 0; v0 = 1'b1; v1 = 1'b1;
      repeat (3) run_cycle();
      fl = 1'b1;
      repeat (10) run_cycle();
      check_val("flush_beats", 32'(beats), 32'd3);
      fl = 1'b0; v0 = 1'b0; v1 = 1'b0;
      repeat (4) run_cycle();

      // reset pulse with four pixels in flight
      v0 = 1'b1; v1 = 1'b1;
      repeat (4) run_cycle();
      n_rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
      #1;
      check_val("arst_out_valid", 32'(out_valid), 32'd0);
      check_val("arst_cv", 32'({cv_r, cv_g, cv_b}), 32'd0);
      q.delete();
      last_is1 = 1'b1;
      repeat (2) run_cycle();
      n_rst = 1'b1; v0 = 1'b1; v1 = 1'b1;
      repeat (10) run_cycle();
      v0 = 1'b0; v1 = 1'b0;
      repeat (8) run_cycle();
      check_val("drained", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ycbcr_conv_arbiter.md
Name: ycbcr_conv_arbiter

Overview:
- Shares one 4-cycle-latency RGB-to-YCbCr converter instance between two pixel requesters (e.g. camera stream and frame-buffer readback).
- Performs per-pixel round-robin arbitration with valid/ready handshakes on the input side.
- Tracks ownership of in-flight pixels with a tag pipeline and reports which requester each converter output belongs to.
- Provides enable masks, a flush/drain control and an idle indicator for the frame-level sequencer.

Parameters:
- BIT_WIDTH, 8, bits per colour component (R/G/B in, Y/Cb/Cr out)
- FRAME_HEIGHT, 480, frame height; V_BITW = ceil(log2(FRAME_HEIGHT))
- FRAME_WIDTH, 640, frame width; H_BITW = ceil(log2(FRAME_WIDTH))
- CONV_LATENCY, 4, converter latency in cycles; tag pipeline depth

Ports:
- clock  in  1  system clock, all logic on rising edge
- n_rst  in  1  asynchronous active-low reset
- enable  in  2  per-requester grant enable, bit i = requester i
- flush  in  1  level; while high no new grants are issued
- idle  out  1  high when no grant this cycle and no pixel in flight
- req0_valid / req1_valid  in  1  requester pixel valid
- req0_ready / req1_ready  out  1  pixel accepted this cycle (combinational grant)
- req0_r,g,b / req1_r,g,b  in  BIT_WIDTH each  requester pixel
- req0_vcnt / req1_vcnt  in  V_BITW  requester row
- req0_hcnt / req1_hcnt  in  H_BITW  requester column
- cv_r, cv_g, cv_b  out  BIT_WIDTH each  to converter input (registered)
- cv_vcnt  out  V_BITW  to converter
- cv_hcnt  out  H_BITW  to converter
- cv_y, cv_cb, cv_cr  in  BIT_WIDTH each  from converter output
- cv_out_vcnt  in  V_BITW  from converter
- cv_out_hcnt  in  H_BITW  from converter
- out_valid  out  2  one-hot owner of current output beat, 0 = none
- out_y, out_cb, out_cr  out  BIT_WIDTH each  registered copy of converter result
- out_vcnt  out  V_BITW  registered copy of converter row
- out_hcnt  out  H_BITW  registered copy of converter column

Behaviour:
- Reset: all outputs 0, tag pipeline cleared, last_grant = 1 (requester 0 wins first). idle = 1 after reset.
- Eligibility: eligible[i] = reqi_valid & enable[i] & ~flush.
- Grant (combinational, same cycle):
  - one eligible requester: it is granted;
  - both eligible: grant the one not equal to last_grant.
  - reqi_ready = grant[i]. At most one grant per cycle.
  - No grant when flush = 1 or enable[i] = 0, even if valid is high.
- last_grant updates only on a cycle with a grant.
- Mux register (stage 0):
  - on grant, register the granted pixel/coords into cv_* and shift tag = grant into the tag pipeline;
  - with no grant, cv_* hold their value and tag = 2'b00.
- Tag pipeline: CONV_LATENCY+1 entries (1 mux register + converter latency).
- Output register: out_* <= cv_* results; out_valid <= tag at the pipeline tail. Total latency req handshake -> out_valid = CONV_LATENCY + 2 cycles (6 at default).
- Throughput: 1 pixel/cycle aggregate. With both requesters continuously valid, the arbiter alternates 0,1,0,1.
- No output backpressure: consumers must accept every out_valid beat.
- Flush: in-flight pixels still complete and emit out_valid. idle rises once the tag pipeline and output register are empty, i.e. out_valid is 0 in that cycle.
- Enable dropped mid-stream: affects only future grants; already-granted pixels complete.
- Async reset mid-operation: tags cleared immediately, so in-flight converter data is discarded (never flagged valid). cv_* return to 0.
- Coordinates are carried through the converter, not regenerated; the block does not check them.

Decomposition:
- Shared package/header holds the REQ_NONE/REQ0/REQ1 one-hot tag constants and a log2 helper for V_BITW/H_BITW.
- One natural sub-module: rr_arbiter2 (two-way round-robin grant with last_grant register).
- The tag shift register stays inline.

Test Plan:
- Reset release, both valid=0 -> idle=1, out_valid=00, all ready=0 for 20 cycles.
- req0 only, continuous, R,G,B = 255,255,255 -> req0_ready every cycle; out_valid=01 from cycle 6; out_y=255, out_cb=out_cr=128 (real converter attached).
- Both valid continuously, 8 pixels each -> grants 0,1,0,1…; out_valid alternates 01,10 with coords matching the sources in order; no pixel lost or duplicated.
- enable=2'b10 with both valid -> req0_ready never high; only out_valid=10 beats appear.
- flush raised with 3 pixels in flight -> no further ready; exactly 3 more out_valid beats; idle=1 in the cycle after the last beat.
- n_rst pulsed low while 4 pixels are in flight -> out_valid=00 immediately and for the following 6 cycles; after release, first grant goes to req0.
